atm_room_access_arbiter: RTL and testbench
==========================================

# atm_room_access_arbiter

Round-robin access controller that shares the single ATM secure room between `N_REQ` entry doors/keypads. It grants one requester at a time, validates that requester's two-digit passcode, unlocks and holds the room until the exit sensor fires, and locks out all access after repeated bad codes. It sits directly in front of the room's lights and door logic, in place of a single-door passcode check.

## Interface
- `N_REQ`, 4, number of entry doors; 2..8
- `PASS_DIGIT_1`, 2'b01, first correct passcode digit
- `PASS_DIGIT_2`, 2'b10, second correct passcode digit
- `ENTRY_TIMEOUT`, 16, cycles allowed for code entry after grant; ≥2
- `MAX_FAIL`, 3, consecutive wrong codes that trigger lockout; 1..7
- `LOCKOUT_CYCLES`, 64, lockout duration in cycles; ≥2

- `clk`  in  1  system clock; all state changes on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `sensor_entry`  in  N_REQ  per-door presence request; level, held while waiting
- `sensor_exit`  in  1  room exit sensor; level, sampled per cycle
- `code_valid`  in  1  one-cycle strobe: the passcode digits are presented this cycle
- `passcode_digit_1`  in  2  first digit from the granted door's keypad
- `passcode_digit_2`  in  2  second digit
- `grant`  out  N_REQ  one-hot door being served; all zero when none
- `GREEN_LIGHT`  out  1  room unlocked/occupied
- `RED_LIGHT`  out  1  room locked
- `alarm`  out  1  lockout active
- `fail_count`  out  3  consecutive wrong codes so far

## Operation
- States: IDLE, WAIT_CODE, OCCUPIED, LOCKOUT. Registered `last_served` pointer, `timer` counter sized for max(ENTRY_TIMEOUT, LOCKOUT_CYCLES).
- IDLE: if any `sensor_entry` bit is set, grant the first set bit searching upward from `(last_served+1) mod N_REQ`, with wrap. Go to WAIT_CODE with timer=0.
- WAIT_CODE: the timer increments each cycle.
  - Correct code: `code_valid` with both digits equal to the parameters. Go to OCCUPIED, clear `fail_count`, and set `last_served` to the granted index.
  - Wrong code: `code_valid` with any digit mismatching. Increment `fail_count` and reset the timer. If the new count equals MAX_FAIL, go to LOCKOUT; otherwise stay.
  - Timeout: no `code_valid` by timer = ENTRY_TIMEOUT-1. Return to IDLE and set `last_served` to the granted index. `fail_count` is kept.
  - Abandon: the granted `sensor_entry` bit drops. Return to IDLE and set `last_served` to the granted index.
- OCCUPIED: `grant` is held and all other requests are ignored. `sensor_exit`=1 returns to IDLE.
- LOCKOUT: `grant` is zero. After LOCKOUT_CYCLES cycles, return to IDLE and clear `fail_count`.
- Outputs are registered and decoded from the state:
  - GREEN=1, RED=0 only in OCCUPIED.
  - `alarm`=1 only in LOCKOUT.
- Priority when events coincide:
  - In WAIT_CODE: `code_valid` beats timeout, and timeout beats abandon. If `code_valid` and a dropped `sensor_entry` arrive together, `code_valid` wins.
  - `sensor_exit` outside OCCUPIED is ignored. `code_valid` outside WAIT_CODE is ignored.
- `fail_count` saturates at MAX_FAIL and is never wider than 3 bits.

## Timing
- Reset (async assert, sync-safe deassert):
  - State and outputs: IDLE, `grant`=0, GREEN=0, RED=1, `alarm`=0, `fail_count`=0.
  - Counters: `last_served`=N_REQ-1, so door 0 has first priority; timer=0.
- Request sampled at edge k gives `grant` valid after edge k (1-cycle latency).
- Correct `code_valid` at edge k gives GREEN=1 and RED=0 after edge k.
- `sensor_exit` at edge k gives GREEN=0, RED=1 and `grant`=0 after edge k. The earliest next grant is edge k+1.
- Lockout entered at edge k ends at edge k+LOCKOUT_CYCLES, which returns to IDLE.
- Timeout: with the grant appearing at edge g and no code, IDLE is reached at edge g+ENTRY_TIMEOUT.
- Reset asserted mid-OCCUPIED or mid-LOCKOUT forces the reset values immediately, without waiting for a clock edge.

## Test plan
- Single user, 20 ns clock:
  - Release reset and set `sensor_entry`=4'b0001.
  - Expect `grant`=0001 after one edge.
  - Send `code_valid` with 01/10. Expect GREEN=1, RED=0.
  - Pulse `sensor_exit`. Expect GREEN=0, RED=1, `grant`=0.
- Round-robin:
  - Hold `sensor_entry`=4'b1011 and serve each grant with a correct code plus exit.
  - Expect grant order 0001 → 0010 → 1000 → 0001.
- Wrong codes:
  - Send three `code_valid` strobes with 00/10.
  - Expect `fail_count` to go 1, 2, 3, then LOCKOUT: `alarm`=1, `grant`=0, RED=1.
  - Requests are ignored for 64 cycles, then IDLE with `fail_count`=0.
- Timeout:
  - Grant door 2 and send no code.
  - Expect `grant`=0 exactly 16 cycles after the grant. With doors 1 and 2 then requesting, door 3 has priority over door 1 because search starts after door 2.
- Collisions:
  - A correct `code_valid` on the timeout cycle must give OCCUPIED.
  - `sensor_exit` in WAIT_CODE must leave `grant` unchanged.
- Async reset:
  - Drop `reset_n` mid-OCCUPIED between clock edges.
  - Expect GREEN=0, RED=1, `grant`=0 before the next edge.

Source files
------------

// File: rtl/atm_room_access_arbiter.sv
// Round-robin access controller for the shared ATM secure room: grants one door at a time,
// checks its two-digit passcode, holds the room until exit, and locks out after repeated bad codes.
module atm_room_access_arbiter #(
    parameter int unsigned N_REQ          = 4,
    parameter logic [1:0]  PASS_DIGIT_1   = 2'b01,
    parameter logic [1:0]  PASS_DIGIT_2   = 2'b10,
    parameter int unsigned ENTRY_TIMEOUT  = 16,
    parameter int unsigned MAX_FAIL       = 3,
    parameter int unsigned LOCKOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] sensor_entry,
    input  logic             sensor_exit,
    input  logic             code_valid,
    input  logic [1:0]       passcode_digit_1,
    input  logic [1:0]       passcode_digit_2,
    output logic [N_REQ-1:0] grant,
    output logic             GREEN_LIGHT,
    output logic             RED_LIGHT,
    output logic             alarm,
    output logic [2:0]       fail_count
);

    localparam int unsigned IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned TMAX = (ENTRY_TIMEOUT > LOCKOUT_CYCLES) ? ENTRY_TIMEOUT : LOCKOUT_CYCLES;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_CODE = 2'd1,
        S_OCCUPIED  = 2'd2,
        S_LOCKOUT   = 2'd3
    } state_t;

    state_t           state, state_d;
    logic [TW-1:0]    timer, timer_d;
    logic [IW-1:0]    last_served, last_served_d;
    logic [IW-1:0]    grant_idx, grant_idx_d;
    logic [2:0]       fail_count_d;
    logic [N_REQ-1:0] grant_d;
    logic             green_d, red_d, alarm_d;

    logic             rr_found;
    logic [IW-1:0]    rr_idx;
    logic [IW-1:0]    rr_cand;

    logic             code_ok;
    logic             entry_timeout;
    logic             lockout_done;
    logic             granted_present;
    logic [2:0]       fail_inc;

    assign code_ok         = (passcode_digit_1 == PASS_DIGIT_1) && (passcode_digit_2 == PASS_DIGIT_2);
    assign entry_timeout   = (timer == TW'(ENTRY_TIMEOUT - 1));
    assign lockout_done    = (timer == TW'(LOCKOUT_CYCLES - 1));
    assign granted_present = |(sensor_entry & grant);
    assign fail_inc        = (fail_count >= 3'(MAX_FAIL)) ? fail_count : fail_count + 3'd1;

    // Round-robin pick: first requesting door after the last one served, with wrap.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_cand  = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            rr_cand = IW'((32'(last_served) + i) % N_REQ);
            if (!rr_found && sensor_entry[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d       = state;
        timer_d       = timer;
        last_served_d = last_served;
        grant_idx_d   = grant_idx;
        fail_count_d  = fail_count;

        case (state)
            S_IDLE: begin
                timer_d = '0;
                if (rr_found) begin
                    state_d     = S_WAIT_CODE;
                    grant_idx_d = rr_idx;
                end
            end
            S_WAIT_CODE: begin
                timer_d = timer + TW'(1);
                if (code_valid) begin
                    if (code_ok) begin
                        state_d       = S_OCCUPIED;
                        fail_count_d  = 3'd0;
                        last_served_d = grant_idx;
                    end else begin
                        fail_count_d = fail_inc;
                        timer_d      = '0;
                        if (fail_inc == 3'(MAX_FAIL)) begin
                            state_d = S_LOCKOUT;
                        end
                    end
                end else if (entry_timeout || !granted_present) begin
                    // Timeout outranks abandon, but both end the same way.
                    state_d       = S_IDLE;
                    timer_d       = '0;
                    last_served_d = grant_idx;
                end
            end
            S_OCCUPIED: begin
                if (sensor_exit) begin
                    state_d = S_IDLE;
                end
            end
            S_LOCKOUT: begin
                timer_d = timer + TW'(1);
                if (lockout_done) begin
                    state_d      = S_IDLE;
                    timer_d      = '0;
                    fail_count_d = 3'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase

        grant_d = '0;
        if (state_d == S_WAIT_CODE || state_d == S_OCCUPIED) begin
            grant_d = N_REQ'(1) << grant_idx_d;
        end
        green_d = (state_d == S_OCCUPIED);
        red_d   = !green_d;
        alarm_d = (state_d == S_LOCKOUT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            timer       <= '0;
            last_served <= IW'(N_REQ - 1);
            grant_idx   <= '0;
            grant       <= '0;
            fail_count  <= 3'd0;
            GREEN_LIGHT <= 1'b0;
            RED_LIGHT   <= 1'b1;
            alarm       <= 1'b0;
        end else begin
            state       <= state_d;
            timer       <= timer_d;
            last_served <= last_served_d;
            grant_idx   <= grant_idx_d;
            grant       <= grant_d;
            fail_count  <= fail_count_d;
            GREEN_LIGHT <= green_d;
            RED_LIGHT   <= red_d;
            alarm       <= alarm_d;
        end
    end

endmodule

// File: tb/tb_atm_room_access_arbiter.sv
// Self-checking bench for atm_room_access_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all compared each cycle against a timestamp-based behavioural model.
module tb_atm_room_access_arbiter;

    localparam int N  = 4;
    localparam int ET = 16;
    localparam int MF = 3;
    localparam int LC = 64;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] sensor_entry = 4'd0;
    logic       sensor_exit = 1'b0;
    logic       code_valid = 1'b0;
    logic [1:0] d1 = 2'd0;
    logic [1:0] d2 = 2'd0;
    logic [3:0] grant;
    logic       green, red, alarm;
    logic [2:0] fail_count;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    atm_room_access_arbiter dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .sensor_entry     (sensor_entry),
        .sensor_exit      (sensor_exit),
        .code_valid       (code_valid),
        .passcode_digit_1 (d1),
        .passcode_digit_2 (d2),
        .grant            (grant),
        .GREEN_LIGHT      (green),
        .RED_LIGHT        (red),
        .alarm            (alarm),
        .fail_count       (fail_count)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 waiting for code, 2 occupied, 3 locked out.
    // Deadlines come from edge timestamps rather than a running counter.
    int cyc    = 0;
    int m_mode = 0;
    int m_door = 0;
    int m_last = N - 1;
    int m_fail = 0;
    int m_t0   = 0;

    task automatic model_reset();
        m_mode = 0;
        m_door = 0;
        m_last = N - 1;
        m_fail = 0;
    endtask

    task automatic model_step();
        int d;
        cyc++;
        case (m_mode)
            0: begin
                for (int k = 1; k <= N; k++) begin
                    d = (m_last + k) % N;
                    if (m_mode == 0 && sensor_entry[d]) begin
                        m_mode = 1;
                        m_door = d;
                        m_t0   = cyc;
                    end
                end
            end
            1: begin
                if (code_valid) begin
                    if (d1 == 2'b01 && d2 == 2'b10) begin
                        m_mode = 2;
                        m_fail = 0;
                        m_last = m_door;
                    end else begin
                        m_fail = (m_fail + 1 > MF) ? MF : m_fail + 1;
                        m_t0   = cyc;
                        if (m_fail == MF) m_mode = 3;
                    end
                end else if (cyc - m_t0 == ET || !sensor_entry[m_door]) begin
                    m_mode = 0;
                    m_last = m_door;
                end
            end
            2: if (sensor_exit) m_mode = 0;
            default: begin
                if (cyc - m_t0 == LC) begin
                    m_mode = 0;
                    m_fail = 0;
                end
            end
        endcase
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else model_step();
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("grant", 32'(grant), (m_mode == 1 || m_mode == 2) ? (32'd1 << m_door) : 32'd0);
            check("green", 32'(green), 32'(m_mode == 2));
            check("red", 32'(red), 32'(m_mode != 2));
            check("alarm", 32'(alarm), 32'(m_mode == 3));
            check("fail_count", 32'(fail_count), 32'(m_fail));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic set_code(input bit ok);
        code_valid = 1'b1;
        d1 = ok ? 2'b01 : 2'b00;
        d2 = 2'b10;
    endtask

    // Expects IDLE with requests present; leaves IDLE after the exit pulse.
    task automatic serve(input logic [3:0] exp_grant, input string name);
        tick();
        check(name, 32'(grant), 32'(exp_grant));
        set_code(1'b1);
        tick();
        code_valid = 1'b0;
        check({name, "_green"}, 32'(green), 32'd1);
        sensor_exit = 1'b1;
        tick();
        sensor_exit = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        cmp_en = 1'b1;
        tick();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_red", 32'(red), 32'd1);
        check("rst_green", 32'(green), 32'd0);
        check("rst_alarm", 32'(alarm), 32'd0);

        // Single user
        reset_n = 1'b1;
        sensor_entry = 4'b0001;
        tick();
        check("single_grant", 32'(grant), 32'h1);
        set_code(1'b1);
        tick();
        code_valid = 1'b0;
        check("single_green", 32'(green), 32'd1);
        check("single_red", 32'(red), 32'd0);
        sensor_exit = 1'b1;
        sensor_entry = 4'b0000;
        tick();
        sensor_exit = 1'b0;
        check("exit_green", 32'(green), 32'd0);
        check("exit_red", 32'(red), 32'd1);
        check("exit_grant", 32'(grant), 32'd0);

        // Round-robin
        do_reset();
        sensor_entry = 4'b1011;
        serve(4'b0001, "rr0");
        serve(4'b0010, "rr1");
        serve(4'b1000, "rr2");
        serve(4'b0001, "rr3");

        // Wrong codes into lockout
        tick();
        check("wc_grant", 32'(grant), 32'b0010);
        set_code(1'b0);
        tick();
        check("wc_fail1", 32'(fail_count), 32'd1);
        tick();
        check("wc_fail2", 32'(fail_count), 32'd2);
        tick();
        code_valid = 1'b0;
        check("wc_fail3", 32'(fail_count), 32'd3);
        check("lock_alarm", 32'(alarm), 32'd1);
        check("lock_grant", 32'(grant), 32'd0);
        check("lock_red", 32'(red), 32'd1);
        repeat (LC - 1) tick();
        check("lock_still", 32'(alarm), 32'd1);
        tick();
        check("lock_end_alarm", 32'(alarm), 32'd0);
        check("lock_end_fail", 32'(fail_count), 32'd0);
        check("lock_end_grant", 32'(grant), 32'd0);

        // Timeout, then priority after door 2
        do_reset();
        sensor_entry = 4'b0100;
        tick();
        check("to_grant", 32'(grant), 32'b0100);
        repeat (ET - 1) tick();
        check("to_hold", 32'(grant), 32'b0100);
        tick();
        check("to_release", 32'(grant), 32'd0);
        sensor_entry = 4'b1010;
        tick();
        check("to_next", 32'(grant), 32'b1000);

        // Correct code on the timeout cycle
        repeat (ET - 1) tick();
        set_code(1'b1);
        tick();
        code_valid = 1'b0;
        check("coll_green", 32'(green), 32'd1);
        sensor_exit = 1'b1;
        tick();
        sensor_exit = 1'b0;
        tick();
        check("wexit_grant0", 32'(grant), 32'b0010);
        sensor_exit = 1'b1;
        tick();
        sensor_exit = 1'b0;
        check("wexit_grant1", 32'(grant), 32'b0010);
        sensor_entry = 4'b0000;
        tick();
        check("abandon", 32'(grant), 32'd0);

        // Async reset mid-OCCUPIED
        sensor_entry = 4'b0001;
        tick();
        set_code(1'b1);
        tick();
        code_valid = 1'b0;
        check("ar_green_pre", 32'(green), 32'd1);
        #3;
        reset_n = 1'b0;
        #2;
        check("ar_green", 32'(green), 32'd0);
        check("ar_red", 32'(red), 32'd1);
        check("ar_grant", 32'(grant), 32'd0);
        tick();
        reset_n = 1'b1;

        // Randomized traffic
        repeat (3000) begin
            if ($urandom_range(7) == 0) sensor_entry = 4'($urandom);
            code_valid = ($urandom_range(3) == 0);
            if ($urandom_range(1) == 0) begin
                d1 = 2'b01;
                d2 = 2'b10;
            end else begin
                d1 = 2'($urandom);
                d2 = 2'($urandom);
            end
            sensor_exit = ($urandom_range(7) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
